// File: rtl/ram_amp_pkg.sv
// Shared types and helpers for the SRAM column / sense-amp access sequencer.
package ram_amp_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_CNT_W  = 4;
  localparam int MAX_CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    GAP,
    DEV,
    SENSE,
    WR,
    RECOV,
    RSP
  } state_t;

  // A programmed phase length of zero still has to last one cycle.
  function automatic logic [MAX_CNT_W-1:0] clamp_to_one(input logic [MAX_CNT_W-1:0] v);
    return (v == '0) ? MAX_CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/ram_phase_timer.sv
// Loadable down-counter that times one analog phase; done marks its last cycle.
module ram_phase_timer import ram_amp_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load with length-1 so the count reaches zero on the phase's final cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - CNT_W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ram_amp_access_ctrl.sv
// Read/write sequencer for the analog SRAM column: precharge, wordline,
// write drive and sense-amp phases, all driven straight from flops.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// PRE   | bitline precharge
// GAP   | break-before-make, every enable low
// DEV   | read: wordline up, bitlines develop
// SENSE | read: wordline down, sense amp enabled
// WR    | write: wordline and write driver up
// RECOV | write: everything low before completion
// RSP   | one-cycle completion strobe
module ram_amp_access_ctrl import ram_amp_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic                     req_wdata,
  input  logic [CNT_W-1:0]         t_pre,
  input  logic [CNT_W-1:0]         t_dev,
  input  logic [CNT_W-1:0]         t_sense,
  output logic                     pch_en,
  output logic [(1<<ADDR_W)-1:0]   wl,
  output logic                     bl_drv_en,
  output logic                     bl_drv_data,
  output logic                     sae,
  input  logic                     sa_out,
  output logic                     rsp_valid,
  output logic                     rsp_rdata,
  output logic                     busy
);

  localparam int ROWS = 1 << ADDR_W;

  state_t            state, state_nxt;
  logic              we_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  tdev_q, tsense_q;
  logic [CNT_W-1:0]  t_pre_c, t_dev_c, t_sense_c;
  logic              accept;
  logic              tmr_load, tmr_done;
  logic [CNT_W-1:0]  tmr_val;
  logic              capture;
  logic              pch_nxt, bl_drv_en_nxt, bl_drv_data_nxt, sae_nxt, rsp_valid_nxt;
  logic [ROWS-1:0]   wl_nxt;

  assign t_pre_c   = CNT_W'(clamp_to_one(MAX_CNT_W'(t_pre)));
  assign t_dev_c   = CNT_W'(clamp_to_one(MAX_CNT_W'(t_dev)));
  assign t_sense_c = CNT_W'(clamp_to_one(MAX_CNT_W'(t_sense)));

  assign req_ready = (state == IDLE);
  assign busy      = !req_ready;
  assign accept    = req_valid && req_ready;
  assign capture   = (state == SENSE) && tmr_done;

  ram_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next state, timer reloads, and the enables for the state being entered.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = t_pre_c;
    case (state)
      IDLE:  if (accept) begin
               state_nxt = PRE;
               tmr_load  = 1'b1;
               tmr_val   = t_pre_c;
             end
      PRE:   if (tmr_done) state_nxt = GAP;
      GAP:   begin
               state_nxt = we_q ? WR : DEV;
               tmr_load  = 1'b1;
               tmr_val   = tdev_q;
             end
      DEV:   if (tmr_done) begin
               state_nxt = SENSE;
               tmr_load  = 1'b1;
               tmr_val   = tsense_q;
             end
      SENSE: if (tmr_done) state_nxt = RSP;
      WR:    if (tmr_done) state_nxt = RECOV;
      RECOV: state_nxt = RSP;
      RSP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    pch_nxt         = (state_nxt == PRE);
    bl_drv_en_nxt   = (state_nxt == WR);
    bl_drv_data_nxt = (state_nxt == WR) && wdata_q;
    sae_nxt         = (state_nxt == SENSE);
    rsp_valid_nxt   = (state_nxt == RSP);
    wl_nxt          = '0;
    if (state_nxt == DEV || state_nxt == WR) wl_nxt[addr_q] = 1'b1;
  end

  // State, request snapshot and registered analog controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      wdata_q     <= 1'b0;
      addr_q      <= '0;
      tdev_q      <= CNT_W'(1);
      tsense_q    <= CNT_W'(1);
      pch_en      <= 1'b0;
      wl          <= '0;
      bl_drv_en   <= 1'b0;
      bl_drv_data <= 1'b0;
      sae         <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pch_en      <= pch_nxt;
      wl          <= wl_nxt;
      bl_drv_en   <= bl_drv_en_nxt;
      bl_drv_data <= bl_drv_data_nxt;
      sae         <= sae_nxt;
      rsp_valid   <= rsp_valid_nxt;
      if (accept) begin
        we_q     <= req_we;
        wdata_q  <= req_wdata;
        addr_q   <= req_addr;
        tdev_q   <= t_dev_c;
        tsense_q <= t_sense_c;
      end
      if (capture) rsp_rdata <= sa_out;
    end
  end

endmodule
